// File: rtl/jt5205_enc.sv
// MSM5205-format ADPCM encoder: quantises one 12-bit PCM sample per handshake into a
// 4-bit nibble, tracking the same predictor and step index as the JT5205 decoder.
module jt5205_enc (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] sample,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic        [3:0]  nibble,
  output logic               nibble_valid,
  output logic signed [11:0] pred,
  output logic        [5:0]  step_idx
);

  // state  | meaning
  // S_IDLE | waiting for a sample; ready is high
  // S_DIFF | form sign and magnitude of sample - pred
  // S_B2   | compare magnitude against step
  // S_B1   | compare remainder against step/2
  // S_B0   | compare remainder against step/4
  // S_UPD  | update predictor and index, emit nibble
  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_B2, S_B1, S_B0, S_UPD} state_t;

  function automatic logic [10:0] step_lut(input logic [5:0] idx);
    case (idx)
      6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  state_t      r_state;
  logic [11:0] r_sample;
  logic [10:0] r_step;
  logic        r_sign;
  logic [12:0] r_mag;
  logic        r_b2, r_b1, r_b0;
  logic        r_ready;
  logic [3:0]  r_nibble;
  logic        r_valid;
  logic [11:0] r_pred;
  logic [5:0]  r_idx;

  logic [12:0] w_diff;
  logic [12:0] w_mag;
  logic [12:0] w_thr;
  logic        w_ge;
  logic [11:0] w_qn;
  logic [11:0] w_pred_nxt;
  logic [6:0]  w_idx_inc;
  logic [5:0]  w_idx_nxt;

  assign w_diff = {r_sample[11], r_sample} - {r_pred[11], r_pred};
  assign w_mag  = w_diff[12] ? (13'd0 - w_diff) : w_diff;

  always_comb begin
    w_thr = {2'b00, r_step};
    case (r_state)
      S_B1:    w_thr = {3'b000, r_step[10:1]};
      S_B0:    w_thr = {4'b0000, r_step[10:2]};
      default: w_thr = {2'b00, r_step};
    endcase
  end

  assign w_ge = (r_mag >= w_thr);

  assign w_qn = {4'd0, r_step[10:3]}
              + (r_b2 ? {1'b0, r_step}          : 12'd0)
              + (r_b1 ? {2'b00, r_step[10:1]}   : 12'd0)
              + (r_b0 ? {3'b000, r_step[10:2]}  : 12'd0);
  assign w_pred_nxt = r_sign ? (r_pred - w_qn) : (r_pred + w_qn);

  // Widened so that 48 + 8 is visible before clamping.
  assign w_idx_inc = {1'b0, r_idx} + {4'd0, r_b1, r_b0, 1'b0} + 7'd2;
  assign w_idx_nxt = r_b2 ? ((w_idx_inc > 7'd48) ? 6'd48 : w_idx_inc[5:0])
                          : ((r_idx == 6'd0) ? 6'd0 : r_idx - 6'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_step   <= '0;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_b2     <= 1'b0;
      r_b1     <= 1'b0;
      r_b0     <= 1'b0;
      r_ready  <= 1'b1;
      r_nibble <= '0;
      r_valid  <= 1'b0;
      r_pred   <= '0;
      r_idx    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (sample_valid) begin
          r_sample <= sample;
          r_step   <= step_lut(r_idx);
          r_ready  <= 1'b0;
          r_state  <= S_DIFF;
        end
        S_DIFF: begin
          r_sign  <= w_diff[12];
          r_mag   <= w_mag;
          r_state <= S_B2;
        end
        S_B2: begin
          r_b2 <= w_ge;
          if (w_ge) r_mag <= r_mag - w_thr;
          r_state <= S_B1;
        end
        S_B1: begin
          r_b1 <= w_ge;
          if (w_ge) r_mag <= r_mag - w_thr;
          r_state <= S_B0;
        end
        S_B0: begin
          r_b0 <= w_ge;
          if (w_ge) r_mag <= r_mag - w_thr;
          r_state <= S_UPD;
        end
        S_UPD: begin
          r_pred   <= w_pred_nxt;
          r_idx    <= w_idx_nxt;
          r_nibble <= {r_sign, r_b2, r_b1, r_b0};
          r_valid  <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = r_ready;
  assign nibble       = r_nibble;
  assign nibble_valid = r_valid;
  assign pred         = r_pred;
  assign step_idx     = r_idx;

endmodule

// File: tb/tb_jt5205_enc.sv
// Bench for jt5205_enc: a per-cycle compare against an arithmetic reference encoder,
// plus literal expectations for the hand-worked vectors.
module tb_jt5205_enc;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [11:0] sample = '0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic        [3:0]  nibble;
  logic               nibble_valid;
  logic signed [11:0] pred;
  logic        [5:0]  step_idx;

  jt5205_enc dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .nibble(nibble), .nibble_valid(nibble_valid),
    .pred(pred), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference encoder: plain integer arithmetic on the quantiser rules.
  int tbl[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,
                  130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,
                  658,724,796,876,963,1060,1166,1282,1411,1552};
  int m_pred = 0;
  int m_idx  = 0;
  int m_nib  = 0;

  task automatic model_encode(input int s);
    int step, diff, mag, q, code;
    step = tbl[m_idx];
    diff = s - m_pred;
    code = (diff < 0) ? 8 : 0;
    mag  = (diff < 0) ? -diff : diff;
    q    = step / 8;
    for (int k = 0; k < 3; k++) begin
      int thr;
      thr = step >> k;
      if (mag >= thr) begin
        code = code | (4 >> k);
        mag  = mag - thr;
        q    = q + thr;
      end
    end
    m_pred = m_pred + (((code & 8) != 0) ? -q : q);
    m_pred = ((m_pred % 4096) + 4096) % 4096;
    if (m_pred >= 2048) m_pred = m_pred - 4096;
    if ((code & 4) != 0) begin
      m_idx = m_idx + 2 * ((code & 3) + 1);
      if (m_idx > 48) m_idx = 48;
    end else begin
      m_idx = (m_idx > 0) ? m_idx - 1 : 0;
    end
    m_nib = code;
  endtask

  typedef struct { int s; int due; } hs_t;
  hs_t hq[$];
  bit  rst_seen = 1'b0;

  always @(negedge clk) begin
    bit exp_valid;
    if (rst_seen) begin
      rst_seen = 1'b0;
      hq.delete();
      m_pred = 0; m_idx = 0; m_nib = 0;
      chk("rst_nibble", nibble, 0);
      chk("rst_valid", nibble_valid, 0);
      chk("rst_pred", int'(pred), 0);
      chk("rst_idx", step_idx, 0);
      chk("rst_ready", sample_ready, 1);
    end else begin
      exp_valid = (hq.size() > 0) && (hq[0].due == cyc);
      if (exp_valid) begin
        model_encode(hq[0].s);
        void'(hq.pop_front());
      end
      chk("nibble_valid", nibble_valid, exp_valid);
      chk("sample_ready", sample_ready, (hq.size() == 0));
      chk("nibble", nibble, m_nib);
      chk("pred", int'(pred), m_pred);
      chk("step_idx", step_idx, m_idx);
      chk("idx_range", (step_idx <= 6'd48), 1);
    end
    if (rst) rst_seen = 1'b1;
    else if (sample_valid && sample_ready) hq.push_back('{int'(sample), cyc + 6});
  end

  task automatic send(input int s);
    int g;
    g = 0;
    @(posedge clk); #1;
    while (!sample_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!sample_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    sample = s[11:0];
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (nibble_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int burst_vals[12] = '{2047, -2048, 2047, -2048, 1000, -1500, 0, 2047, 2047, -2048, -2048, 5};

  initial begin
    int n, cnt, g, last, pulses;
    bit rdy;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Zero input from reset: index clamps at 0, predictor gains step>>3.
    send(0); wait_valid(n);
    chk("latency", n, 5);
    chk("zero_nib", nibble, 4'b0000);
    chk("zero_pred", int'(pred), 2);
    chk("zero_idx", step_idx, 0);

    do_reset();
    send(100); wait_valid(n);
    chk("p100_nib", nibble, 4'b0111);
    chk("p100_pred", int'(pred), 30);
    chk("p100_idx", step_idx, 8);
    send(-100); wait_valid(n);
    chk("m100_nib", nibble, 4'b1111);
    chk("m100_pred", int'(pred), -33);
    chk("m100_idx", step_idx, 16);

    // Sustained full-scale input drives the index to its ceiling.
    do_reset();
    for (int i = 0; i < 20; i++) begin send(2047); wait_valid(n); end
    // Track the predictor exactly: index must walk down one per sample.
    for (int i = 0; i < 55; i++) begin
      @(negedge clk); #1;
      send(m_pred); wait_valid(n);
    end
    chk("decay_idx", step_idx, 0);

    // sample_valid pulsed while busy must be ignored.
    send(500);
    @(posedge clk); #1 sample = -700; sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    wait_valid(n);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (nibble_valid) pulses++;
    end
    chk("busy_pulse_extra", pulses, 0);

    // Continuous valid: one accept per 6 clocks, with wrap-provoking swings.
    cnt = 0; g = 0; last = -1;
    @(posedge clk); #1;
    sample = burst_vals[0][11:0];
    sample_valid = 1'b1;
    while (cnt < 12 && g < 200) begin
      rdy = sample_ready;
      @(posedge clk);
      g++;
      if (rdy) begin
        if (last >= 0) chk("burst_spacing", g - last, 6);
        last = g;
        cnt++;
        #1;
        if (cnt < 12) sample = burst_vals[cnt][11:0];
      end else begin
        #1;
      end
    end
    sample_valid = 1'b0;
    chk("burst_count", cnt, 12);
    repeat (8) @(posedge clk);

    // Reset while the encoder sits in B1.
    send(1234);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("b1rst_valid", nibble_valid, 0);
    chk("b1rst_pred", int'(pred), 0);
    chk("b1rst_idx", step_idx, 0);
    chk("b1rst_ready", sample_ready, 1);
    rst = 1'b0;
    repeat (8) @(posedge clk);

    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(4095)) - 2048);
      wait_valid(n);
    end
    for (int i = 0; i < 200; i++) begin
      send(int'($rtoi(1900.0 * $sin(2.0 * 3.14159265 * i / 48.0))));
      wait_valid(n);
    end

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
